// File: rtl/vga_timing_gen.sv
// Raster timing for the tic-tac-toe renderer: pixel-tick divider, x/y scan
// counters, active-video decode and HSYNC/VSYNC delayed to line up with colour.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_tick;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_frame_start;

  logic             w_div_last;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_hs_raw;
  logic             w_vs_raw;
  logic [1:0]       w_sync_raw;

  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign w_x_last   = (r_x == H_LAST);
  assign w_y_last   = (r_y == V_LAST);

  // Tick is registered from the terminal count, so the first tick after
  // reset release lands CLK_DIV clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt  <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      if (w_div_last) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      r_pix_tick <= w_div_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= r_pix_tick && w_x_last && w_y_last;
      if (r_pix_tick) begin
        if (w_x_last) begin
          r_x <= '0;
          if (w_y_last) begin
            r_y <= '0;
          end else begin
            r_y <= r_y + 10'd1;
          end
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

  assign w_hs_raw   = !((r_x >= H_SYNC_BEG) && (r_x < H_SYNC_END));
  assign w_vs_raw   = !((r_y >= V_SYNC_BEG) && (r_y < V_SYNC_END));
  assign w_sync_raw = {w_vs_raw, w_hs_raw};

  // Syncs are delayed by the renderer's colour latency; the line runs every
  // clk, independent of the pixel tick.
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign {vsync, hsync} = w_sync_raw;
    end else begin : g_dly
      logic [PIPE_DLY-1:0][1:0] r_sync_pipe;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync_pipe <= '1;
        end else begin
          r_sync_pipe[0] <= w_sync_raw;
          for (int unsigned i = 1; i < PIPE_DLY; i++) begin
            r_sync_pipe[i] <= r_sync_pipe[i-1];
          end
        end
      end

      assign {vsync, hsync} = r_sync_pipe[PIPE_DLY-1];
    end
  endgenerate

  assign pix_tick    = r_pix_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign en          = (r_x < H_ACT) && (r_y < V_ACT);
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-timing instances (divide-by-4 with a
// 2-clk sync delay, divide-by-1 with no delay) checked against a closed-form model.
module tb_vga_timing_gen;

  localparam int unsigned HA = 20, HF = 3, HS = 4, HB = 3;
  localparam int unsigned VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;

  logic       a_tick, a_en, a_hs, a_vs, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_en, b_hs, b_vs, b_fs;
  logic [9:0] b_x, b_y;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .pix_tick(a_tick), .x(a_x), .y(a_y),
    .en(a_en), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .pix_tick(b_tick), .x(b_x), .y(b_y),
    .en(b_en), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
  );

  typedef struct {
    int unsigned x, y;
    bit tick, en, hs, vs, fs;
  } exp_t;

  typedef struct {
    int unsigned n;
    int unsigned x, y;
    bit tick, en, hs, vs, fs;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n      = 0;   // clk edges since reset release
  vec_t        tbl[16];

  // Measurement state per instance (0 = dut_a, 1 = dut_b)
  int unsigned m_counting[2], m_done[2], m_ticks[2], m_ens[2], m_fs_n[2], m_fs_cnt[2];
  int unsigned m_x23_n[2], m_y10_n[2], m_hs_start[2], m_vs_start[2], m_hs_runs[2], m_vs_runs[2];
  bit          m_hs_seen[2], m_vs_seen[2], m_prev_hs[2], m_prev_vs[2];
  logic [9:0]  m_prev_x[2], m_prev_y[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d t=%0t: got %0d expected %0d", name, n, $time, act, exp);
    end
  endtask

  // Closed-form reference: pixel position is the number of completed ticks.
  function automatic int unsigned pos(input int unsigned d, input int unsigned k);
    return (k == 0) ? 0 : (k - 1) / d;
  endfunction

  function automatic exp_t model(input int unsigned d, input int unsigned pd, input int unsigned k);
    exp_t        e;
    int unsigned p, ph, hx, hy;
    p      = pos(d, k);
    e.x    = p % HT;
    e.y    = (p / HT) % VT;
    e.tick = (k >= d) && (k % d == 0);
    e.en   = (e.x < HA) && (e.y < VA);
    ph     = pos(d, (k >= pd) ? k - pd : 0);
    hx     = ph % HT;
    hy     = (ph / HT) % VT;
    e.hs   = !((hx >= HA + HF) && (hx < HA + HF + HS));
    e.vs   = !((hy >= VA + VF) && (hy < VA + VF + VS));
    e.fs   = (k >= 1) && (p != pos(d, k - 1)) && (p % (HT * VT) == 0);
    return e;
  endfunction

  task automatic cmp_all();
    exp_t ea, eb;
    ea = model(4, 2, n);
    eb = model(1, 0, n);
    chk("a_x",    32'(a_x),    ea.x);
    chk("a_y",    32'(a_y),    ea.y);
    chk("a_tick", 32'(a_tick), 32'(ea.tick));
    chk("a_en",   32'(a_en),   32'(ea.en));
    chk("a_hs",   32'(a_hs),   32'(ea.hs));
    chk("a_vs",   32'(a_vs),   32'(ea.vs));
    chk("a_fs",   32'(a_fs),   32'(ea.fs));
    chk("b_x",    32'(b_x),    eb.x);
    chk("b_y",    32'(b_y),    eb.y);
    chk("b_tick", 32'(b_tick), 32'(eb.tick));
    chk("b_en",   32'(b_en),   32'(eb.en));
    chk("b_hs",   32'(b_hs),   32'(eb.hs));
    chk("b_vs",   32'(b_vs),   32'(eb.vs));
    chk("b_fs",   32'(b_fs),   32'(eb.fs));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) n++;
    @(negedge clk);
    cmp_all();
  endtask

  task automatic chk_reset();
    chk("rst_a_x", 32'(a_x), 0);      chk("rst_a_y", 32'(a_y), 0);
    chk("rst_a_tick", 32'(a_tick), 0); chk("rst_a_fs", 32'(a_fs), 0);
    chk("rst_a_hs", 32'(a_hs), 1);     chk("rst_a_vs", 32'(a_vs), 1);
    chk("rst_a_en", 32'(a_en), 1);
    chk("rst_b_x", 32'(b_x), 0);      chk("rst_b_y", 32'(b_y), 0);
    chk("rst_b_tick", 32'(b_tick), 0); chk("rst_b_fs", 32'(b_fs), 0);
    chk("rst_b_hs", 32'(b_hs), 1);     chk("rst_b_vs", 32'(b_vs), 1);
    chk("rst_b_en", 32'(b_en), 1);
  endtask

  task automatic meas_init(input int idx, input logic hs, input logic vs,
                           input logic [9:0] xv, input logic [9:0] yv);
    m_counting[idx] = 0; m_done[idx] = 0; m_ticks[idx] = 0; m_ens[idx] = 0;
    m_fs_n[idx] = 0; m_fs_cnt[idx] = 0; m_x23_n[idx] = 0; m_y10_n[idx] = 0;
    m_hs_start[idx] = 0; m_vs_start[idx] = 0; m_hs_runs[idx] = 0; m_vs_runs[idx] = 0;
    m_hs_seen[idx] = 0; m_vs_seen[idx] = 0;
    m_prev_hs[idx] = hs; m_prev_vs[idx] = vs; m_prev_x[idx] = xv; m_prev_y[idx] = yv;
  endtask

  task automatic measure(input int idx, input logic tick, input logic en, input logic fs,
                         input logic hs, input logic vs,
                         input logic [9:0] xv, input logic [9:0] yv);
    int unsigned d, pd;
    d  = (idx == 0) ? 4 : 1;
    pd = (idx == 0) ? 2 : 0;
    if (xv == 10'd23 && m_prev_x[idx] != 10'd23) m_x23_n[idx] = n;
    if (yv == 10'd10 && m_prev_y[idx] != 10'd10) m_y10_n[idx] = n;
    if (!hs && m_prev_hs[idx]) begin
      chk("hs_fall_delay", n - m_x23_n[idx], pd);
      m_hs_start[idx] = n; m_hs_seen[idx] = 1;
    end
    if (hs && !m_prev_hs[idx] && m_hs_seen[idx]) begin
      chk("hs_low_clks", n - m_hs_start[idx], HS * d);
      m_hs_runs[idx]++;
    end
    if (!vs && m_prev_vs[idx]) begin
      chk("vs_fall_delay", n - m_y10_n[idx], pd);
      m_vs_start[idx] = n; m_vs_seen[idx] = 1;
    end
    if (vs && !m_prev_vs[idx] && m_vs_seen[idx]) begin
      chk("vs_low_clks", n - m_vs_start[idx], VS * HT * d);
      m_vs_runs[idx]++;
    end
    if (m_counting[idx] != 0 && tick) begin
      m_ticks[idx]++;
      if (en) m_ens[idx]++;
    end
    if (fs) begin
      m_fs_cnt[idx]++;
      if (m_counting[idx] != 0) begin
        chk("frame_clks",   n - m_fs_n[idx], HT * VT * d);
        chk("frame_ticks",  m_ticks[idx], HT * VT);
        chk("frame_en_pix", m_ens[idx], HA * VA);
        m_counting[idx] = 0; m_done[idx] = 1;
      end else if (m_done[idx] == 0) begin
        m_counting[idx] = 1;
      end
      m_fs_n[idx] = n;
    end
    m_prev_hs[idx] = hs; m_prev_vs[idx] = vs; m_prev_x[idx] = xv; m_prev_y[idx] = yv;
  endtask

  initial begin
    int unsigned k;

    tbl[0]  = '{0,    0,  0,  0, 1, 1, 1, 0};
    tbl[1]  = '{3,    0,  0,  0, 1, 1, 1, 0};
    tbl[2]  = '{4,    0,  0,  1, 1, 1, 1, 0};
    tbl[3]  = '{5,    1,  0,  0, 1, 1, 1, 0};
    tbl[4]  = '{8,    1,  0,  1, 1, 1, 1, 0};
    tbl[5]  = '{94,   23, 0,  0, 0, 1, 1, 0};
    tbl[6]  = '{95,   23, 0,  0, 0, 0, 1, 0};
    tbl[7]  = '{110,  27, 0,  0, 0, 0, 1, 0};
    tbl[8]  = '{111,  27, 0,  0, 0, 1, 1, 0};
    tbl[9]  = '{120,  29, 0,  1, 0, 1, 1, 0};
    tbl[10] = '{121,  0,  1,  0, 1, 1, 1, 0};
    tbl[11] = '{1202, 0,  10, 0, 0, 1, 1, 0};
    tbl[12] = '{1203, 0,  10, 0, 0, 1, 0, 0};
    tbl[13] = '{1800, 29, 14, 1, 0, 1, 1, 0};
    tbl[14] = '{1801, 0,  0,  0, 1, 1, 1, 1};
    tbl[15] = '{1802, 0,  0,  0, 1, 1, 1, 0};

    // Power-on reset, then the fixed vector table on the divide-by-4 instance
    repeat (3) step();
    reset_n = 1'b1;
    n = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      while (n < tbl[i].n) step();
      chk("tbl_x",    32'(a_x),    tbl[i].x);
      chk("tbl_y",    32'(a_y),    tbl[i].y);
      chk("tbl_tick", 32'(a_tick), 32'(tbl[i].tick));
      chk("tbl_en",   32'(a_en),   32'(tbl[i].en));
      chk("tbl_hs",   32'(a_hs),   32'(tbl[i].hs));
      chk("tbl_vs",   32'(a_vs),   32'(tbl[i].vs));
      chk("tbl_fs",   32'(a_fs),   32'(tbl[i].fs));
    end

    // Mid-frame asynchronous reset while hsync pipeline is low
    while (n < 2500) step();
    chk("mid_a_x_nonzero", 32'(a_x != 10'd0), 1);
    #2 reset_n = 1'b0;
    n = 0;
    #1 chk_reset();
    step(); step();
    reset_n = 1'b1;
    k = 0;
    while (!a_tick && k < 20) begin step(); k++; end
    chk("first_tick_delay", k, 4);
    step();
    chk("x_after_first_tick", 32'(a_x), 1);

    // Line/frame/sync structure measured directly over ~2.7 frames
    meas_init(0, a_hs, a_vs, a_x, a_y);
    meas_init(1, b_hs, b_vs, b_x, b_y);
    while (n < 5000) begin
      step();
      measure(0, a_tick, a_en, a_fs, a_hs, a_vs, a_x, a_y);
      measure(1, b_tick, b_en, b_fs, b_hs, b_vs, b_x, b_y);
    end
    chk("a_frame_pulses", m_fs_cnt[0], 2);
    chk("b_frame_pulses", m_fs_cnt[1], 11);
    chk("a_frame_measured", m_done[0], 1);
    chk("b_frame_measured", m_done[1], 1);
    chk("a_hs_runs_seen", 32'(m_hs_runs[0] != 0), 1);
    chk("b_hs_runs_seen", 32'(m_hs_runs[1] != 0), 1);
    chk("a_vs_runs_seen", 32'(m_vs_runs[0] != 0), 1);
    chk("b_vs_runs_seen", 32'(m_vs_runs[1] != 0), 1);

    // Random run lengths with randomly placed asynchronous resets
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(20, 2500);
      repeat (k) step();
      #($urandom_range(1, 3)) reset_n = 1'b0;
      n = 0;
      #1 chk_reset();
      repeat ($urandom_range(1, 4)) step();
      reset_n = 1'b1;
    end
    repeat ($urandom_range(100, 1000)) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
